imem_loader: RTL and testbench
==============================

Name: imem_loader

Overview:
- Boot-time writer for the instruction memory region at 0xBFC00000.
- Accepts a byte stream over a valid/ready handshake, for example from a UART receiver or testbench.
- Assembles bytes into little-endian 32-bit words and issues one word write per 4 bytes.
- Holds the CPU in reset until the image is fully written, then releases it.

Parameters:
- BASE_ADDR, 32'hBFC00000, byte address of the first word written.
- MEM_BYTES, 4096, size of the writable region in bytes; must be a multiple of 4.
- ADDRESS_WIDTH, 32, width of mem_addr.
- DATA_WIDTH, 8, width of one stream byte.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; begins a load; ignored unless in IDLE, DONE or ERROR.
- rx_data  in  8  stream byte.
- rx_valid  in  1  rx_data is valid.
- rx_ready  out  1  loader accepts a byte this cycle; transfer occurs when rx_valid and rx_ready are both 1.
- mem_we  out  1  one-cycle word write strobe.
- mem_addr  out  32  word-aligned byte address of the write.
- mem_wdata  out  32  little-endian word; the first byte of each group goes to bits 7:0.
- cpu_hold  out  1  keeps the CPU in reset while 1.
- busy  out  1  in HEADER, LOAD or CHECK.
- done  out  1  image loaded successfully; sticky until the next start.
- err  out  1  load failed; sticky until the next start.

Behaviour:
- Reset values: rx_ready=0, mem_we=0, mem_addr=BASE_ADDR, mem_wdata=0, cpu_hold=1, busy=0, done=0, err=0. State is IDLE and all counters are 0.
- Reset asserted mid-load aborts immediately; no further mem_we is issued.
- States: IDLE, HEADER, LOAD, CHECK, DONE, ERROR.
- IDLE: cpu_hold=1. On start, go to HEADER and clear the byte index, word index and length register.
- HEADER: rx_ready=1. Accept 4 bytes forming N, the word count, little-endian.
  - After the 4th byte, N==0 goes to DONE (or to CHECK with CHECKSUM_EN).
  - N*4 > MEM_BYTES goes to ERROR; compare without overflow, using a 33-bit product.
  - Otherwise go to LOAD.
- LOAD: rx_ready=1. Each accepted byte is placed in lane byte_idx of the assembly register, and byte_idx (2 bits) wraps 3->0.
  - On acceptance of lane 3, the next cycle drives mem_we=1, mem_addr=BASE_ADDR+4*word_idx, and mem_wdata equal to the complete word.
  - word_idx then increments.
  - Write latency is exactly 1 cycle after the 4th byte handshake.
  - Back-to-back bytes are accepted every cycle; no stall is needed.
  - After word N-1 is written, go to DONE (or to CHECK).
- DONE: done=1, cpu_hold=0, rx_ready=0.
- ERROR: err=1, cpu_hold=1, rx_ready=0.
- The transition into DONE or ERROR takes effect the cycle after the triggering byte. For the final word, this is the same cycle as its mem_we.
- start pulses during busy are ignored.
- A start in DONE or ERROR clears done/err, reasserts cpu_hold the next cycle, and goes to HEADER.
- rx_valid with rx_ready=0 is not consumed; bytes presented outside a load are left to the upstream block.
- mem_we is never asserted outside LOAD and never for addresses at or beyond BASE_ADDR+MEM_BYTES.

Optional Feature:
- Macro: IMEM_LOADER_CHECKSUM_EN.
- When defined:
  - After the last word, the CHECK state accepts one byte, with rx_ready=1.
  - The expected byte is the XOR of all header and payload bytes.
  - Match goes to DONE; mismatch goes to ERROR.
  - An 8-bit running XOR register is reset on start.
- When undefined: CHECK is absent, with no register and no trailing byte; the load ends directly in DONE.

Decomposition:
- Package imem_loader_pkg holds:
  - the state enum loader_state_t;
  - localparams WORD_BYTES=4 and HDR_BYTES=4;
  - a function for the word-count bound check.
- One sub-module is natural: word_assembler, which handles byte-lane packing, byte_idx and the word_ready pulse.
- The FSM, address generation and checksum stay in imem_loader.

Test Plan:
- Nominal load: start, then header 02 00 00 00, then 13 05 00 00 93 05 10 00 -> mem_we twice: (0xBFC00000, 0x00000513), then (0xBFC00004, 0x00100593); then done=1 and cpu_hold=0.
- Zero length: header 00 00 00 00 -> no mem_we; done=1 the cycle after the 4th header byte.
- Oversize: header 01 04 00 00 (1025 words) -> no mem_we; err=1, cpu_hold=1, rx_ready=0.
- Gapped stream: rx_valid toggled randomly; 1 word DE AD BE EF -> a single write of 0xEFBEADDE.
- Mid-load reset: rst_n low after 6 payload bytes -> all outputs return to reset values immediately; a new start with a 1-word image writes to 0xBFC00000.
- CHECKSUM_EN: header 01 00 00 00, payload 11 22 33 44, trailer 45 -> done. The same image with trailer 00 -> err=1 and cpu_hold stays 1.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// -----------------------------------------------------------------------------
// imem_loader_pkg
// Shared types and helpers for the boot-time instruction memory loader.
//   loader_state_t : loader FSM states
//   WORD_BYTES     : bytes per memory word
//   HDR_BYTES      : bytes in the little-endian word-count header
//   len_exceeds()  : word-count bound check against the writable region
// -----------------------------------------------------------------------------
package imem_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_HEADER = 3'd1,
        ST_LOAD   = 3'd2,
        ST_CHECK  = 3'd3,
        ST_DONE   = 3'd4,
        ST_ERROR  = 3'd5
    } loader_state_t;

    localparam int WORD_BYTES = 4;
    localparam int HDR_BYTES  = 4;

    // True when n_words words do not fit in mem_bytes bytes. The product is
    // formed wide enough that a huge header value cannot wrap to a small one.
    function automatic logic len_exceeds(input logic [31:0] n_words,
                                         input logic [31:0] mem_bytes);
        logic [33:0] n_bytes_s;
        n_bytes_s = 34'(n_words) * 34'(WORD_BYTES);
        return (n_bytes_s > {2'b00, mem_bytes});
    endfunction

endpackage

// File: rtl/imem_loader_word_assembler.sv
// -----------------------------------------------------------------------------
// imem_loader_word_assembler
// Packs a byte stream into little-endian 32-bit words.
//   clk, rst_n  : clock, asynchronous active-low reset
//   srst        : synchronous clear of the lane index and partial word
//   byte_take   : a byte is transferred this cycle
//   payload     : the transferred byte belongs to the image payload
//   byte_in     : stream byte
//   byte_idx    : lane the next byte lands in (wraps 3 -> 0)
//   word_last   : current transfer completes a word (lane 3)
//   word_full   : combinational word including the current byte (valid with word_last)
//   word_ready  : registered one-cycle pulse after a payload word completes
//   word_data   : registered payload word presented with word_ready
// -----------------------------------------------------------------------------
module imem_loader_word_assembler
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        srst,
    input  logic        byte_take,
    input  logic        payload,
    input  logic [7:0]  byte_in,
    output logic [1:0]  byte_idx,
    output logic        word_last,
    output logic [31:0] word_full,
    output logic        word_ready,
    output logic [31:0] word_data
);

    logic [1:0]  byte_idx_r;
    logic [23:0] lane_r;
    logic        word_ready_r;
    logic [31:0] word_data_r;
    logic        word_last_s;

    assign word_last_s = (byte_idx_r == 2'(WORD_BYTES - 1));
    // Lane 3 never touches lane_r; it is taken straight from the input.
    assign word_full   = {byte_in, lane_r};
    assign word_last   = word_last_s;
    assign byte_idx    = byte_idx_r;
    assign word_ready  = word_ready_r;
    assign word_data   = word_data_r;

    // Lane index, partial word and the registered completed-word pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_idx_r   <= 2'd0;
            lane_r       <= 24'd0;
            word_ready_r <= 1'b0;
            word_data_r  <= 32'd0;
        end else if (srst) begin
            byte_idx_r   <= 2'd0;
            lane_r       <= 24'd0;
            word_ready_r <= 1'b0;
        end else begin
            word_ready_r <= byte_take && payload && word_last_s;
            if (byte_take) begin
                byte_idx_r <= byte_idx_r + 2'd1;
                case (byte_idx_r)
                    2'd0:    lane_r[7:0]   <= byte_in;
                    2'd1:    lane_r[15:8]  <= byte_in;
                    2'd2:    lane_r[23:16] <= byte_in;
                    default: lane_r        <= lane_r;
                endcase
                if (payload && word_last_s) begin
                    word_data_r <= {byte_in, lane_r};
                end
            end
        end
    end

endmodule

// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
// Boot-time writer for the instruction memory region. Receives a 4-byte
// little-endian word count N followed by N little-endian words over a
// valid/ready byte stream, writes them from BASE_ADDR upward and holds the CPU
// in reset until the whole image is in place.
// Optional build macro IMEM_LOADER_CHECKSUM_EN: a trailing byte equal to the XOR
// of all header and payload bytes must follow the image.
//   clk, rst_n        : clock, asynchronous active-low reset
//   start             : begins a load from IDLE, DONE or ERROR
//   rx_data/valid     : stream byte and its valid
//   rx_ready          : loader accepts a byte this cycle
//   mem_we/addr/wdata : one-cycle word write
//   cpu_hold          : CPU reset hold
//   busy, done, err   : status; done/err sticky until next start
// -----------------------------------------------------------------------------
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR     = 32'hBFC00000,
    parameter int          MEM_BYTES     = 4096,
    parameter int          ADDRESS_WIDTH = 32,
    parameter int          DATA_WIDTH    = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [DATA_WIDTH-1:0]    rx_data,
    input  logic                     rx_valid,
    output logic                     rx_ready,
    output logic                     mem_we,
    output logic [ADDRESS_WIDTH-1:0] mem_addr,
    output logic [31:0]              mem_wdata,
    output logic                     cpu_hold,
    output logic                     busy,
    output logic                     done,
    output logic                     err
);

    localparam logic [31:0] MAX_WORDS = 32'(MEM_BYTES / WORD_BYTES);

`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam loader_state_t ST_END = ST_CHECK;
`else
    localparam loader_state_t ST_END = ST_DONE;
`endif

    loader_state_t state_r;
    loader_state_t state_next_s;

    logic        rx_ready_r, busy_r, done_r, err_r, cpu_hold_r;
    logic        rx_ready_s, busy_s, done_s, err_s, cpu_hold_s;
    logic [ADDRESS_WIDTH-1:0] mem_addr_r;
    logic [31:0] word_idx_r;
    logic [31:0] len_r;

    logic        take_s;
    logic        start_go_s;
    logic        payload_s;
    logic        hdr_done_s;
    logic        write_s;
    logic [1:0]  byte_idx_s;
    logic        word_last_s;
    logic [31:0] word_full_s;
    logic        word_ready_s;
    logic [31:0] word_data_s;

    // rx_ready_r always mirrors the current state, so it qualifies the handshake.
    assign take_s     = rx_valid && rx_ready_r;
    assign start_go_s = start && ((state_r == ST_IDLE) || (state_r == ST_DONE) ||
                                  (state_r == ST_ERROR));
    // Out-of-range words are never flagged as payload, so no write can escape the region.
    assign payload_s  = (state_r == ST_LOAD) && (word_idx_r < MAX_WORDS);
    assign hdr_done_s = (state_r == ST_HEADER) && take_s &&
                        (byte_idx_s == 2'(HDR_BYTES - 1));
    assign write_s    = payload_s && take_s && word_last_s;

    imem_loader_word_assembler u_asm (
        .clk        (clk),
        .rst_n      (rst_n),
        .srst       (start_go_s),
        .byte_take  (take_s),
        .payload    (payload_s),
        .byte_in    (rx_data[7:0]),
        .byte_idx   (byte_idx_s),
        .word_last  (word_last_s),
        .word_full  (word_full_s),
        .word_ready (word_ready_s),
        .word_data  (word_data_s)
    );

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0] xor_r;

    // Running XOR of every header and payload byte.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xor_r <= 8'd0;
        end else if (start_go_s) begin
            xor_r <= 8'd0;
        end else if (take_s && ((state_r == ST_HEADER) || (state_r == ST_LOAD))) begin
            xor_r <= xor_r ^ rx_data[7:0];
        end else begin
            xor_r <= xor_r;
        end
    end
`endif

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_next_s = ST_HEADER;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_HEADER: begin
                if (hdr_done_s) begin
                    if (word_full_s == 32'd0) begin
                        state_next_s = ST_END;
                    end else if (len_exceeds(word_full_s, 32'(MEM_BYTES))) begin
                        state_next_s = ST_ERROR;
                    end else begin
                        state_next_s = ST_LOAD;
                    end
                end else begin
                    state_next_s = ST_HEADER;
                end
            end
            ST_LOAD: begin
                if (!payload_s) begin
                    state_next_s = ST_ERROR;
                end else if (write_s && (word_idx_r == (len_r - 32'd1))) begin
                    state_next_s = ST_END;
                end else begin
                    state_next_s = ST_LOAD;
                end
            end
            ST_CHECK: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                if (take_s) begin
                    if (rx_data[7:0] == xor_r) begin
                        state_next_s = ST_DONE;
                    end else begin
                        state_next_s = ST_ERROR;
                    end
                end else begin
                    state_next_s = ST_CHECK;
                end
`else
                state_next_s = ST_ERROR;
`endif
            end
            ST_DONE, ST_ERROR: begin
                if (start) begin
                    state_next_s = ST_HEADER;
                end else begin
                    state_next_s = state_r;
                end
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // Moore outputs decoded from the next state so the registered copies line up with state_r.
    always_comb begin
        rx_ready_s = 1'b0;
        busy_s     = 1'b0;
        done_s     = 1'b0;
        err_s      = 1'b0;
        cpu_hold_s = 1'b1;
        case (state_next_s)
            ST_HEADER, ST_LOAD, ST_CHECK: begin
                rx_ready_s = 1'b1;
                busy_s     = 1'b1;
            end
            ST_DONE: begin
                done_s     = 1'b1;
                cpu_hold_s = 1'b0;
            end
            ST_ERROR: begin
                err_s      = 1'b1;
            end
            default: begin
                cpu_hold_s = 1'b1;
            end
        endcase
    end

    // Registered status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_ready_r <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            err_r      <= 1'b0;
            cpu_hold_r <= 1'b1;
        end else begin
            rx_ready_r <= rx_ready_s;
            busy_r     <= busy_s;
            done_r     <= done_s;
            err_r      <= err_s;
            cpu_hold_r <= cpu_hold_s;
        end
    end

    // Word count, word index and write address.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_idx_r <= 32'd0;
            len_r      <= 32'd0;
            mem_addr_r <= ADDRESS_WIDTH'(BASE_ADDR);
        end else if (start_go_s) begin
            word_idx_r <= 32'd0;
            len_r      <= 32'd0;
        end else begin
            if (hdr_done_s) begin
                len_r <= word_full_s;
            end else begin
                len_r <= len_r;
            end
            if (write_s) begin
                word_idx_r <= word_idx_r + 32'd1;
                mem_addr_r <= ADDRESS_WIDTH'(BASE_ADDR) +
                              ADDRESS_WIDTH'({word_idx_r[29:0], 2'b00});
            end else begin
                word_idx_r <= word_idx_r;
            end
        end
    end

    assign rx_ready  = rx_ready_r;
    assign busy      = busy_r;
    assign done      = done_r;
    assign err       = err_r;
    assign cpu_hold  = cpu_hold_r;
    assign mem_we    = word_ready_s;
    assign mem_addr  = mem_addr_r;
    assign mem_wdata = word_data_s;

endmodule

// File: tb/tb_imem_loader.sv
// -----------------------------------------------------------------------------
// tb_imem_loader
// Directed self-checking bench for imem_loader. Inputs are driven and outputs
// sampled 1 time unit after each rising edge. Define IMEM_LOADER_CHECKSUM_EN for
// both bench and RTL to exercise the trailing checksum byte.
// -----------------------------------------------------------------------------
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  rx_data = 8'd0;
    logic        rx_valid = 1'b0;
    logic        rx_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        cpu_hold;
    logic        busy;
    logic        done;
    logic        err;

    int n_total = 0;
    int n_pass  = 0;
    int wr_count = 0;

    imem_loader dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .cpu_hold  (cpu_hold),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    // Count every write strobe seen mid-cycle.
    always @(negedge clk) begin
        if (mem_we === 1'b1) wr_count++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    // Present one byte until the handshake completes (bounded).
    task automatic send_byte(input logic [7:0] b);
        logic hs;
        hs = 1'b0;
        rx_data  = b;
        rx_valid = 1'b1;
        for (int k = 0; k < 20 && !hs; k++) begin
            hs = rx_ready;
            tick(1);
        end
        rx_valid = 1'b0;
        if (!hs) check("handshake_timeout", 32'd0, 32'd1);
    endtask

    task automatic send_word(input logic [31:0] w);
        send_byte(w[7:0]);
        send_byte(w[15:8]);
        send_byte(w[23:16]);
        send_byte(w[31:24]);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_rx_ready"}, {31'd0, rx_ready}, 32'd0);
        check({tag, "_mem_we"},   {31'd0, mem_we},   32'd0);
        check({tag, "_mem_addr"}, mem_addr,          32'hBFC00000);
        check({tag, "_mem_wdata"}, mem_wdata,        32'd0);
        check({tag, "_cpu_hold"}, {31'd0, cpu_hold}, 32'd1);
        check({tag, "_busy"},     {31'd0, busy},     32'd0);
        check({tag, "_done"},     {31'd0, done},     32'd0);
        check({tag, "_err"},      {31'd0, err},      32'd0);
    endtask

    initial begin
        // Reset state
        tick(2);
        check_reset_values("reset");
        rst_n = 1'b1;
        tick(2);

        // Nominal two-word load
        pulse_start();
        check("nom_busy", {31'd0, busy}, 32'd1);
        check("nom_rx_ready", {31'd0, rx_ready}, 32'd1);
        check("nom_hold", {31'd0, cpu_hold}, 32'd1);
        send_word(32'h00000002);
        check("nom_hdr_busy", {31'd0, busy}, 32'd1);
        check("nom_hdr_no_we", {31'd0, mem_we}, 32'd0);
        send_word(32'h00000513);
        check("nom_w0_we", {31'd0, mem_we}, 32'd1);
        check("nom_w0_addr", mem_addr, 32'hBFC00000);
        check("nom_w0_data", mem_wdata, 32'h00000513);
        check("nom_w0_not_done", {31'd0, done}, 32'd0);
        tick(1);
        check("nom_we_pulse", {31'd0, mem_we}, 32'd0);
        send_word(32'h00100593);
        check("nom_w1_we", {31'd0, mem_we}, 32'd1);
        check("nom_w1_addr", mem_addr, 32'hBFC00004);
        check("nom_w1_data", mem_wdata, 32'h00100593);
`ifdef IMEM_LOADER_CHECKSUM_EN
        check("nom_check_wait", {31'd0, done}, 32'd0);
        send_byte(8'h92);
`endif
        check("nom_done", {31'd0, done}, 32'd1);
        check("nom_release", {31'd0, cpu_hold}, 32'd0);
        check("nom_rx_ready_off", {31'd0, rx_ready}, 32'd0);
        check("nom_idle_busy", {31'd0, busy}, 32'd0);
        tick(2);
        check("nom_wr_count", wr_count, 32'd2);
        check("nom_done_sticky", {31'd0, done}, 32'd1);

        // Zero-length image
        pulse_start();
        check("zero_done_cleared", {31'd0, done}, 32'd0);
        check("zero_hold_again", {31'd0, cpu_hold}, 32'd1);
        send_word(32'h00000000);
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_byte(8'h00);
`endif
        check("zero_done", {31'd0, done}, 32'd1);
        check("zero_no_we", {31'd0, mem_we}, 32'd0);
        tick(2);
        check("zero_wr_count", wr_count, 32'd2);

        // Oversize image: 1025 words
        pulse_start();
        send_word(32'h00000401);
        check("over_err", {31'd0, err}, 32'd1);
        check("over_hold", {31'd0, cpu_hold}, 32'd1);
        check("over_rx_ready", {31'd0, rx_ready}, 32'd0);
        check("over_busy", {31'd0, busy}, 32'd0);
        check("over_done", {31'd0, done}, 32'd0);
        rx_data  = 8'h5A;
        rx_valid = 1'b1;
        tick(3);
        rx_valid = 1'b0;
        check("over_err_sticky", {31'd0, err}, 32'd1);
        check("over_wr_count", wr_count, 32'd2);

        // Exactly 1024 words fits; abort with reset after 6 payload bytes
        pulse_start();
        check("max_err_cleared", {31'd0, err}, 32'd0);
        send_word(32'h00000400);
        check("max_accepted_busy", {31'd0, busy}, 32'd1);
        check("max_accepted_err", {31'd0, err}, 32'd0);
        send_word(32'h00000513);
        check("max_w0_addr", mem_addr, 32'hBFC00000);
        send_byte(8'h93);
        send_byte(8'h05);
        rst_n = 1'b0;
        #1;
        check_reset_values("midrst");
        tick(3);
        check("midrst_wr_count", wr_count, 32'd3);
        rst_n = 1'b1;
        tick(1);

        // Gapped single-word load after the reset
        pulse_start();
        send_word(32'h00000001);
        rx_valid = 1'b0;
        tick($urandom_range(0, 3));
        send_byte(8'hDE);
        tick($urandom_range(1, 3));
        send_byte(8'hAD);
        tick($urandom_range(1, 3));
        send_byte(8'hBE);
        tick($urandom_range(1, 3));
        send_byte(8'hEF);
        check("gap_we", {31'd0, mem_we}, 32'd1);
        check("gap_addr", mem_addr, 32'hBFC00000);
        check("gap_data", mem_wdata, 32'hEFBEADDE);
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_byte(8'h23);
`endif
        check("gap_done", {31'd0, done}, 32'd1);
        tick(2);
        check("gap_wr_count", wr_count, 32'd4);

`ifdef IMEM_LOADER_CHECKSUM_EN
        // Checksum match and mismatch
        pulse_start();
        send_word(32'h00000001);
        send_word(32'h44332211);
        send_byte(8'h45);
        check("cks_good_done", {31'd0, done}, 32'd1);
        check("cks_good_err", {31'd0, err}, 32'd0);
        pulse_start();
        send_word(32'h00000001);
        send_word(32'h44332211);
        send_byte(8'h00);
        check("cks_bad_err", {31'd0, err}, 32'd1);
        check("cks_bad_hold", {31'd0, cpu_hold}, 32'd1);
        check("cks_bad_done", {31'd0, done}, 32'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
